// File: rtl/pipe_pkg.sv
// Shared encodings and stage control bundles for the 5-stage pipeline hazard controller.
package pipe_pkg;

    localparam int ALU_OP_W = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // The jump bit is consumed in ID, so it is not carried past ID/EX.
    typedef struct packed {
        logic                reg_dst;
        logic                branch;
        logic                bne;
        logic                mem_read;
        logic                memto_reg;
        logic                mem_write;
        logic                alu_src;
        logic                reg_write;
        logic [ALU_OP_W-1:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic memto_reg;
        logic reg_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic memto_reg;
        logic reg_write;
    } wb_ctrl_t;

    localparam ex_ctrl_t  BUBBLE     = '0;
    localparam mem_ctrl_t MEM_BUBBLE = '0;
    localparam wb_ctrl_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX-stage operand forwarding select; EX/MEM result beats MEM/WB result.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] ex_rs,
    input  logic [RA_W-1:0] ex_rt,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] mem_dest,
    input  logic            wb_reg_write,
    input  logic [RA_W-1:0] wb_dest,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                           input logic            m_we,
                                           input logic [RA_W-1:0] m_dst,
                                           input logic            w_we,
                                           input logic [RA_W-1:0] w_dst);
        logic [1:0] sel;
        sel = FWD_RF;
        if (m_we && (m_dst != '0) && (m_dst == src)) begin
            sel = FWD_MEM;
        end else if (w_we && (w_dst != '0) && (w_dst == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_reg_write, mem_dest, wb_reg_write, wb_dest);
        fwd_b = fwd_sel(ex_rt, mem_reg_write, mem_dest, wb_reg_write, wb_dest);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: carries decoded controls ID->EX->MEM->WB, handles load-use stalls,
// branch/jump redirects and flushes, and drives the EX operand forwarding selects.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int AOP_W = ALU_OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg_dst,
    input  logic             id_jump,
    input  logic             id_branch,
    input  logic             id_bne,
    input  logic             id_mem_read,
    input  logic             id_memto_reg,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic [AOP_W-1:0] id_alu_op,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             ex_alu_zero,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [1:0]       pc_src,
    output logic             ex_reg_dst,
    output logic             ex_alu_src,
    output logic [AOP_W-1:0] ex_alu_op,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             wb_reg_write,
    output logic             wb_memto_reg,
    output logic [RA_W-1:0]  wb_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    ex_ctrl_t        idex_ctrl_q, idex_ctrl_d;
    logic [RA_W-1:0] idex_rs_q, idex_rs_d;
    logic [RA_W-1:0] idex_rt_q, idex_rt_d;
    logic [RA_W-1:0] idex_rd_q, idex_rd_d;
    mem_ctrl_t       exmem_ctrl_q, exmem_ctrl_d;
    logic [RA_W-1:0] exmem_dest_q, exmem_dest_d;
    wb_ctrl_t        memwb_ctrl_q, memwb_ctrl_d;
    logic [RA_W-1:0] memwb_dest_q, memwb_dest_d;

    logic       branch_taken;
    logic       load_use;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    always_comb begin
        branch_taken = (idex_ctrl_q.branch & ex_alu_zero) | (idex_ctrl_q.bne & ~ex_alu_zero);
        load_use     = idex_ctrl_q.mem_read && (idex_rt_q != '0) &&
                       ((idex_rt_q == id_rs) || (id_uses_rt && (idex_rt_q == id_rt)));
    end

    // A taken branch outranks everything in ID: that instruction is on the wrong path.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pc_src     = PC_SEL_SEQ;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
        end else if (branch_taken) begin
            pc_src     = PC_SEL_BRANCH;
            ifid_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (id_jump) begin
            pc_src     = PC_SEL_JUMP;
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        idex_ctrl_d = BUBBLE;
        idex_rs_d   = '0;
        idex_rt_d   = '0;
        idex_rd_d   = '0;
        if (!(branch_taken || load_use)) begin
            idex_ctrl_d.reg_dst   = id_reg_dst;
            idex_ctrl_d.branch    = id_branch;
            idex_ctrl_d.bne       = id_bne;
            idex_ctrl_d.mem_read  = id_mem_read;
            idex_ctrl_d.memto_reg = id_memto_reg;
            idex_ctrl_d.mem_write = id_mem_write;
            idex_ctrl_d.alu_src   = id_alu_src;
            idex_ctrl_d.reg_write = id_reg_write;
            idex_ctrl_d.alu_op    = id_alu_op;
            idex_rs_d             = id_rs;
            idex_rt_d             = id_rt;
            idex_rd_d             = id_rd;
        end

        exmem_ctrl_d.mem_read  = idex_ctrl_q.mem_read;
        exmem_ctrl_d.mem_write = idex_ctrl_q.mem_write;
        exmem_ctrl_d.memto_reg = idex_ctrl_q.memto_reg;
        exmem_ctrl_d.reg_write = idex_ctrl_q.reg_write;
        exmem_dest_d           = idex_ctrl_q.reg_dst ? idex_rd_q : idex_rt_q;

        memwb_ctrl_d.memto_reg = exmem_ctrl_q.memto_reg;
        memwb_ctrl_d.reg_write = exmem_ctrl_q.reg_write;
        memwb_dest_d           = exmem_dest_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ctrl_q  <= BUBBLE;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            idex_rd_q    <= '0;
            exmem_ctrl_q <= MEM_BUBBLE;
            exmem_dest_q <= '0;
            memwb_ctrl_q <= WB_BUBBLE;
            memwb_dest_q <= '0;
        end else begin
            idex_ctrl_q  <= idex_ctrl_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            idex_rd_q    <= idex_rd_d;
            exmem_ctrl_q <= exmem_ctrl_d;
            exmem_dest_q <= exmem_dest_d;
            memwb_ctrl_q <= memwb_ctrl_d;
            memwb_dest_q <= memwb_dest_d;
        end
    end

    fwd_unit #(.RA_W(RA_W)) u_fwd (
        .ex_rs         (idex_rs_q),
        .ex_rt         (idex_rt_q),
        .mem_reg_write (exmem_ctrl_q.reg_write),
        .mem_dest      (exmem_dest_q),
        .wb_reg_write  (memwb_ctrl_q.reg_write),
        .wb_dest       (memwb_dest_q),
        .fwd_a         (fwd_a_raw),
        .fwd_b         (fwd_b_raw)
    );

    always_comb begin
        fwd_a         = rst ? FWD_RF : fwd_a_raw;
        fwd_b         = rst ? FWD_RF : fwd_b_raw;
        ex_reg_dst    = idex_ctrl_q.reg_dst;
        ex_alu_src    = idex_ctrl_q.alu_src;
        ex_alu_op     = idex_ctrl_q.alu_op;
        mem_mem_read  = exmem_ctrl_q.mem_read;
        mem_mem_write = exmem_ctrl_q.mem_write;
        wb_reg_write  = memwb_ctrl_q.reg_write;
        wb_memto_reg  = memwb_ctrl_q.memto_reg;
        wb_dest       = memwb_dest_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stalls, forwarding, branch/jump redirects, $0 and reset.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_reg_dst, id_jump, id_branch, id_bne, id_mem_read, id_memto_reg;
    logic       id_mem_write, id_alu_src, id_reg_write, id_uses_rt;
    logic [1:0] id_alu_op;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_alu_zero;
    logic       pc_write, ifid_write, ifid_flush;
    logic [1:0] pc_src;
    logic       ex_reg_dst, ex_alu_src;
    logic [1:0] ex_alu_op;
    logic       mem_mem_read, mem_mem_write, wb_reg_write, wb_memto_reg;
    logic [4:0] wb_dest;
    logic [1:0] fwd_a, fwd_b;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_reg_dst(id_reg_dst), .id_jump(id_jump), .id_branch(id_branch), .id_bne(id_bne),
        .id_mem_read(id_mem_read), .id_memto_reg(id_memto_reg), .id_mem_write(id_mem_write),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
        .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_alu_zero(ex_alu_zero),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .pc_src(pc_src),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .wb_reg_write(wb_reg_write), .wb_memto_reg(wb_memto_reg), .wb_dest(wb_dest),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic pcw, input logic ifw,
                           input logic fl, input logic [1:0] src);
        chk({tag, ".pc_write"}, 8'(pc_write), 8'(pcw));
        chk({tag, ".ifid_write"}, 8'(ifid_write), 8'(ifw));
        chk({tag, ".ifid_flush"}, 8'(ifid_flush), 8'(fl));
        chk({tag, ".pc_src"}, 8'(pc_src), 8'(src));
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, ".fwd_a"}, 8'(fwd_a), 8'(a));
        chk({tag, ".fwd_b"}, 8'(fwd_b), 8'(b));
    endtask

    task automatic set_id(input logic rdst, input logic jmp, input logic br, input logic bn,
                          input logic mr, input logic m2r, input logic mw, input logic asrc,
                          input logic rw, input logic [1:0] aop, input logic urt,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_reg_dst = rdst; id_jump = jmp; id_branch = br; id_bne = bn;
        id_mem_read = mr; id_memto_reg = m2r; id_mem_write = mw; id_alu_src = asrc;
        id_reg_write = rw; id_alu_op = aop; id_uses_rt = urt;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic i_nop();                                    set_id(0,0,0,0,0,0,0,0,0,2'b00,0,0,0,0);   endtask
    task automatic i_lw(input logic [4:0] rs, input logic [4:0] rt);  set_id(0,0,0,0,1,1,0,1,1,2'b00,0,rs,rt,0); endtask
    task automatic i_addi(input logic [4:0] rs, input logic [4:0] rt); set_id(0,0,0,0,0,0,0,1,1,2'b00,0,rs,rt,0); endtask
    task automatic i_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_id(1,0,0,0,0,0,0,0,1,2'b10,1,rs,rt,rd);
    endtask
    task automatic i_beq(input logic [4:0] rs, input logic [4:0] rt); set_id(0,0,1,0,0,0,0,0,0,2'b01,1,rs,rt,0); endtask
    task automatic i_bne(input logic [4:0] rs, input logic [4:0] rt); set_id(0,0,0,1,0,0,0,0,0,2'b01,1,rs,rt,0); endtask
    task automatic i_j(input logic [4:0] rs);                  set_id(0,1,0,0,0,0,0,0,0,2'b00,0,rs,0,0);  endtask

    initial begin
        rst = 1'b1;
        ex_alu_zero = 1'b0;
        i_nop();

        // Reset hold
        repeat (3) begin
            @(negedge clk); #1;
            chk_ctl("rst", 0, 0, 1, 2'b00);
            chk_fwd("rst", 2'b00, 2'b00);
        end
        @(negedge clk); rst = 1'b0; i_nop(); #1;
        chk_ctl("rel", 1, 1, 0, 2'b00);
        chk("rel.wb_reg_write", 8'(wb_reg_write), 8'd0);
        chk("rel.wb_memto_reg", 8'(wb_memto_reg), 8'd0);
        chk("rel.wb_dest", 8'(wb_dest), 8'd0);
        chk("rel.mem_mem_read", 8'(mem_mem_read), 8'd0);

        // lw $2,0($1) ; add $3,$2,$4
        @(negedge clk); i_lw(1, 2); #1;
        chk_ctl("lw", 1, 1, 0, 2'b00);
        @(negedge clk); i_rtype(2, 4, 3); #1;
        chk_ctl("lu_stall", 0, 0, 0, 2'b00);
        chk("lu_stall.ex_alu_src", 8'(ex_alu_src), 8'd1);
        @(negedge clk); #1;
        chk_ctl("lu_resume", 1, 1, 0, 2'b00);
        chk("lu_resume.ex_alu_src", 8'(ex_alu_src), 8'd0);
        chk("lu_resume.mem_mem_read", 8'(mem_mem_read), 8'd1);
        @(negedge clk); i_nop(); #1;
        chk("lu_add.ex_reg_dst", 8'(ex_reg_dst), 8'd1);
        chk("lu_add.ex_alu_op", 8'(ex_alu_op), 8'd2);
        chk_fwd("lu_add", 2'b01, 2'b00);
        chk("lu_add.wb_reg_write", 8'(wb_reg_write), 8'd1);
        chk("lu_add.wb_memto_reg", 8'(wb_memto_reg), 8'd1);
        chk("lu_add.wb_dest", 8'(wb_dest), 8'd2);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("add_wb.wb_dest", 8'(wb_dest), 8'd3);
        chk("add_wb.wb_memto_reg", 8'(wb_memto_reg), 8'd0);

        // add $2,$1,$1 ; sub $3,$2,$2
        @(negedge clk); i_rtype(1, 1, 2); #1;
        @(negedge clk); set_id(1,0,0,0,0,0,0,0,1,2'b10,1,2,2,3); #1;
        chk_ctl("sub_id", 1, 1, 0, 2'b00);
        @(negedge clk); i_nop(); #1;
        chk_fwd("sub_ex", 2'b10, 2'b10);
        @(negedge clk); #1;
        @(negedge clk); #1;

        // EX/MEM beats MEM/WB on the same register
        @(negedge clk); i_addi(1, 5); #1;
        @(negedge clk); i_addi(5, 5); #1;
        chk_fwd("pri_a", 2'b00, 2'b00);
        @(negedge clk); i_rtype(5, 5, 6); #1;
        chk_fwd("pri_b", 2'b10, 2'b10);
        @(negedge clk); i_nop(); #1;
        chk_fwd("pri_c", 2'b10, 2'b10);
        @(negedge clk); #1;
        @(negedge clk); #1;

        // beq taken in EX with a jump in ID: branch wins
        @(negedge clk); i_beq(1, 1); #1;
        @(negedge clk); i_j(1); ex_alu_zero = 1'b1; #1;
        chk_ctl("beq_taken", 1, 1, 1, 2'b01);
        @(negedge clk); i_nop(); ex_alu_zero = 1'b0; #1;
        chk_ctl("beq_after", 1, 1, 0, 2'b00);
        chk("beq_after.ex_alu_op", 8'(ex_alu_op), 8'd0);

        // jump held by a load-use stall, then redirects
        @(negedge clk); i_lw(1, 7); #1;
        @(negedge clk); i_j(7); #1;
        chk_ctl("j_stalled", 0, 0, 0, 2'b00);
        @(negedge clk); #1;
        chk_ctl("j_go", 1, 1, 1, 2'b10);
        @(negedge clk); i_nop(); #1;
        chk_ctl("j_after", 1, 1, 0, 2'b00);
        chk("j_after.ex_alu_src", 8'(ex_alu_src), 8'd0);

        // bne with zero=1 not taken; bne with zero=0 taken
        @(negedge clk); i_bne(1, 2); #1;
        @(negedge clk); i_bne(1, 2); ex_alu_zero = 1'b1; #1;
        chk_ctl("bne_nt", 1, 1, 0, 2'b00);
        @(negedge clk); i_nop(); ex_alu_zero = 1'b0; #1;
        chk_ctl("bne_t", 1, 1, 1, 2'b01);
        @(negedge clk); #1;

        // writes to $0 never forward, lw $0 never stalls
        @(negedge clk); i_addi(1, 0); #1;
        @(negedge clk); i_lw(1, 0); #1;
        @(negedge clk); i_rtype(0, 0, 3); #1;
        chk_ctl("r0_nostall", 1, 1, 0, 2'b00);
        chk_fwd("r0_a", 2'b00, 2'b00);
        @(negedge clk); i_nop(); #1;
        chk_fwd("r0_b", 2'b00, 2'b00);

        // reset asserted mid-stall discards in-flight state
        @(negedge clk); i_lw(1, 2); #1;
        @(negedge clk); i_rtype(2, 2, 4); rst = 1'b1; #1;
        chk_ctl("rst_stall", 0, 0, 1, 2'b00);
        @(negedge clk); rst = 1'b0; i_nop(); #1;
        chk_ctl("rst_clear", 1, 1, 0, 2'b00);
        chk("rst_clear.ex_alu_src", 8'(ex_alu_src), 8'd0);
        chk("rst_clear.mem_mem_read", 8'(mem_mem_read), 8'd0);
        chk("rst_clear.wb_reg_write", 8'(wb_reg_write), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
